// File: rtl/mc_core_p.sv
`timescale 1ns/1ps
// mc_core_p: parametrised multicycle MIPS-subset core (bne optional via MC_CORE_BNE_EN); 2-5 cycles per instr.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR one extra cycle each, with address and data stable.
module mc_core_p #(
  parameter int WIDTH = 32,
  parameter int NREG = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       state
);

  localparam int RIDX = $clog2(NREG);
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_r, state_n;

  logic [WIDTH-1:0] pc_r, data_r, a_r, b_r, aluout_r;
  logic [31:0]      ir_r;
  logic [WIDTH-1:0] rf [NREG];

  logic [5:0]       opcode, funct;
  logic [RIDX-1:0]  ir_rs, ir_rt, ir_rd;
  logic [WIDTH-1:0] sign_imm, jump_tgt, rd1, rd2, sub_y;
  logic             zero, is_branch, br_taken;

  logic             iord, we_c, ir_we, pc_we, ab_we, alu_we, data_we, rf_we;
  logic [WIDTH-1:0] pc_n, alu_n, rf_wd;
  logic [RIDX-1:0]  rf_wa;

  assign opcode   = ir_r[31:26];
  assign funct    = ir_r[5:0];
  assign ir_rs    = ir_r[20+RIDX:21];
  assign ir_rt    = ir_r[15+RIDX:16];
  assign ir_rd    = ir_r[10+RIDX:11];
  assign sign_imm = {{(WIDTH-16){ir_r[15]}}, ir_r[15:0]};
  assign jump_tgt = {pc_r[WIDTH-1:28], ir_r[25:0], 2'b00};

  // shamt and the high register-index bits are never decoded
  logic unused_ir;
  assign unused_ir = ^ir_r;

  assign rd1   = (ir_rs == '0) ? '0 : rf[ir_rs];
  assign rd2   = (ir_rt == '0) ? '0 : rf[ir_rt];
  assign sub_y = a_r - b_r;
  assign zero  = (sub_y == '0);

`ifdef MC_CORE_BNE_EN
  localparam logic [5:0] OP_BNE = 6'h05;
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign br_taken  = (opcode == OP_BNE) ? !zero : zero;
`else
  assign is_branch = (opcode == OP_BEQ);
  assign br_taken  = zero;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_r <= S_FETCH;
    else        state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    iord    = 1'b0;
    we_c    = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_n    = pc_r + FOUR;
    ab_we   = 1'b0;
    alu_we  = 1'b0;
    alu_n   = aluout_r;
    data_we = 1'b0;
    rf_we   = 1'b0;
    rf_wa   = ir_rt;
    rf_wd   = aluout_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we  = 1'b1;
        alu_we = 1'b1;
        alu_n  = pc_r + (sign_imm << 2);
        if (is_branch) state_n = S_BRANCH;
        else begin
          case (opcode)
            OP_LW, OP_SW: state_n = S_MEMADR;
            OP_RTYPE:     state_n = S_EXEC;
            OP_ADDI:      state_n = S_ADDIEX;
            OP_J:         state_n = S_JUMP;
            default:      state_n = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_we  = 1'b1;
        alu_n   = a_r + sign_imm;
        state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          data_we = 1'b1;
          state_n = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = data_r;
        state_n = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        we_c = 1'b1;
        if (mem_ready) state_n = S_FETCH;
      end
      S_EXEC: begin
        alu_we  = 1'b1;
        state_n = S_ALUWB;
        case (funct)
          6'h20:   alu_n = a_r + b_r;
          6'h22:   alu_n = sub_y;
          6'h24:   alu_n = a_r & b_r;
          6'h25:   alu_n = a_r | b_r;
          6'h2A:   alu_n = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
          default: begin
            alu_we  = 1'b0;
            state_n = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        rf_wa   = ir_rd;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        if (br_taken) begin
          pc_we = 1'b1;
          pc_n  = aluout_r;
        end
        state_n = S_FETCH;
      end
      S_ADDIEX: begin
        alu_we  = 1'b1;
        alu_n   = a_r + sign_imm;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we   = 1'b1;
        state_n = S_FETCH;
      end
      S_JUMP: begin
        pc_we   = 1'b1;
        pc_n    = jump_tgt;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r     <= RESET_PC;
      ir_r     <= '0;
      data_r   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      aluout_r <= '0;
    end else begin
      if (ir_we)   ir_r     <= mem_rd[31:0];
      if (pc_we)   pc_r     <= pc_n;
      if (ab_we) begin
        a_r <= rd1;
        b_r <= rd2;
      end
      if (alu_we)  aluout_r <= alu_n;
      if (data_we) data_r   <= mem_rd;
    end
  end

  // Register file keeps its contents across reset; a reset cycle only blocks the write
  always_ff @(posedge clk) begin
    if (reset && rf_we && (rf_wa != '0)) rf[rf_wa] <= rf_wd;
  end

  assign mem_adr = iord ? aluout_r : pc_r;
  assign mem_wd  = b_r;
  assign mem_we  = we_c & reset;
  assign pc      = pc_r;
  assign state   = state_r;

endmodule

// File: tb/tb_mc_core_p.sv
`timescale 1ns/1ps
// Directed bench for mc_core_p: 32-bit/32-reg core (A) and 64-bit/8-reg core (B), each with its own memory.
module tb_mc_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, rdy_a, mem_we_a;
  logic [31:0] adr_a, wd_a, rd_a, pc_a;
  logic [3:0]  st_a;
  logic [31:0] mem_a [256];

  logic        reset_b, rdy_b, mem_we_b;
  logic [63:0] adr_b, wd_b, rd_b, pc_b;
  logic [3:0]  st_b;
  logic [63:0] mem_b [256];

  mc_core_p #(.WIDTH(32), .NREG(32), .RESET_PC(32'h100)) dut_a (
    .clk(clk), .reset(reset_a), .mem_adr(adr_a), .mem_wd(wd_a), .mem_we(mem_we_a),
    .mem_rd(rd_a), .mem_ready(rdy_a), .pc(pc_a), .state(st_a));

  mc_core_p #(.WIDTH(64), .NREG(8), .RESET_PC(64'h100)) dut_b (
    .clk(clk), .reset(reset_b), .mem_adr(adr_b), .mem_wd(wd_b), .mem_we(mem_we_b),
    .mem_rd(rd_b), .mem_ready(rdy_b), .pc(pc_b), .state(st_b));

  assign rd_a = mem_a[adr_a[9:2]];
  assign rd_b = mem_b[adr_b[9:2]];

  int n_checks = 0;
  int n_errors = 0;
  int we_n, we_moved;
  logic [63:0] we_adr, we_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // One clock; memory writes land just after the edge they were strobed on
  task automatic tick();
    logic wa, wb;
    logic [7:0] ia, ib;
    logic [31:0] da;
    logic [63:0] db;
    wa = mem_we_a && rdy_a; ia = adr_a[9:2]; da = wd_a;
    wb = mem_we_b && rdy_b; ib = adr_b[9:2]; db = wd_b;
    @(posedge clk);
    #1;
    if (wa) mem_a[ia] = da;
    if (wb) mem_b[ib] = db;
  endtask

  task automatic run_instr(input bit b, input int fs_in, input int ms_in, output int cyc);
    int fs, ms;
    bit left;
    logic [3:0] st;
    logic rdy;
    logic [63:0] adr, wd;
    fs = fs_in; ms = ms_in; left = 1'b0; cyc = 0; we_n = 0; we_moved = 0;
    while (cyc < 60) begin
      st  = b ? st_b : st_a;
      rdy = 1'b1;
      if (st == 4'd0 && fs > 0) begin
        rdy = 1'b0; fs--;
      end else if ((st == 4'd3 || st == 4'd5) && ms > 0) begin
        rdy = 1'b0; ms--;
      end
      if (b) rdy_b = rdy; else rdy_a = rdy;
      adr = b ? adr_b : 64'(adr_a);
      wd  = b ? wd_b  : 64'(wd_a);
      if (b ? mem_we_b : mem_we_a) begin
        if (we_n == 0) begin
          we_adr = adr; we_wd = wd;
        end else if (adr != we_adr || wd != we_wd) we_moved++;
        we_n++;
      end
      tick();
      cyc++;
      st = b ? st_b : st_a;
      if (st != 4'd0) left = 1'b1;
      else if (left) break;
    end
    rdy_a = 1'b1;
    rdy_b = 1'b1;
  endtask

  task automatic exec(input string tag, input bit b, input int fs, input int ms, input int exp_cyc);
    int cyc;
    run_instr(b, fs, ms, cyc);
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic b_prologue();
    exec("b_addi_r9", 1'b1, 0, 0, 4);
    exec("b_addi_r2", 1'b1, 0, 0, 4);
    exec("b_addi_r3", 1'b1, 0, 0, 4);
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[16] = 32'hDEADBEEF;
    mem_a[17] = 32'h12345678;
    mem_a[36] = 32'hAAAAAAAA;
    mem_a[64] = itype(6'h08, 0, 1, 16'h0030);
    mem_a[65] = itype(6'h23, 1, 2, 16'h0010);
    mem_a[66] = itype(6'h08, 2, 3, 16'hFFFF);
    mem_a[67] = itype(6'h23, 0, 4, 16'h0044);
    mem_a[68] = itype(6'h2B, 0, 4, 16'h0004);
    mem_a[69] = itype(6'h08, 0, 1, 16'h0005);
    mem_a[70] = itype(6'h08, 0, 2, 16'hFFFD);
    mem_a[71] = rtype(1, 2, 3, 6'h2A);
    mem_a[72] = rtype(2, 1, 3, 6'h2A);
    mem_a[73] = rtype(2, 1, 5, 6'h22);
    mem_a[74] = rtype(5, 4, 6, 6'h24);
    mem_a[75] = rtype(1, 4, 7, 6'h25);
    mem_a[76] = rtype(1, 1, 0, 6'h20);
    mem_a[77] = itype(6'h2B, 0, 0, 16'h0090);
    mem_a[78] = rtype(1, 1, 3, 6'h21);
    mem_a[79] = itype(6'h04, 1, 1, 16'h0002);
    mem_a[80] = itype(6'h08, 0, 3, 16'h0077);
    mem_a[81] = itype(6'h08, 0, 3, 16'h0077);
    mem_a[82] = itype(6'h04, 1, 2, 16'h0005);
    mem_a[83] = itype(6'h3F, 0, 3, 16'h0099);
    mem_a[84] = itype(6'h05, 1, 2, 16'h0002);
    mem_a[85] = jtype(26'h40);
    mem_a[86] = itype(6'h08, 0, 3, 16'h0077);
    mem_a[87] = jtype(26'h40);

    mem_b[16] = 64'h0123456789ABCDEF;
    mem_b[64] = 64'(itype(6'h08, 0, 9, 16'h0007));
    mem_b[65] = 64'(itype(6'h08, 0, 2, 16'hFFFF));
    mem_b[66] = 64'(itype(6'h08, 0, 3, 16'h0055));
    mem_b[67] = 64'(itype(6'h23, 0, 3, 16'h0040));

    tick();
    tick();
    check("rst_pc", 64'(pc_a), 64'h100);
    check("rst_state", 64'(st_a), 64'h0);
    check("rst_we", 64'(mem_we_a), 64'h0);
    check("rst_adr", 64'(adr_a), 64'h100);
    check("rst_wd", 64'(wd_a), 64'h0);
    reset_a = 1'b1;
    check("fetch_adr", 64'(adr_a), 64'h100);

    exec("addi_r1_stall", 1'b0, 2, 0, 6);
    check("r1", 64'(dut_a.rf[1]), 64'h30);
    exec("lw_r2", 1'b0, 0, 0, 5);
    check("r2_lw", 64'(dut_a.rf[2]), 64'hDEADBEEF);
    exec("addi_r3", 1'b0, 0, 0, 4);
    check("r3_addi", 64'(dut_a.rf[3]), 64'hDEADBEEE);
    exec("lw_r4_stall", 1'b0, 0, 1, 6);
    check("r4_lw", 64'(dut_a.rf[4]), 64'h12345678);
    exec("sw_stall", 1'b0, 0, 3, 7);
    check("sw_we_cycles", 64'(we_n), 64'd4);
    check("sw_adr", we_adr, 64'h4);
    check("sw_wd", we_wd, 64'h12345678);
    check("sw_stable", 64'(we_moved), 64'd0);
    check("sw_mem", 64'(mem_a[1]), 64'h12345678);

    exec("addi_r1", 1'b0, 0, 0, 4);
    exec("addi_r2", 1'b0, 0, 0, 4);
    check("r2_neg", 64'(dut_a.rf[2]), 64'hFFFFFFFD);
    exec("slt_a", 1'b0, 0, 0, 4);
    check("slt_5_lt_m3", 64'(dut_a.rf[3]), 64'h0);
    exec("slt_b", 1'b0, 0, 0, 4);
    check("slt_m3_lt_5", 64'(dut_a.rf[3]), 64'h1);
    exec("sub", 1'b0, 0, 0, 4);
    check("sub_r5", 64'(dut_a.rf[5]), 64'hFFFFFFF8);
    exec("and", 1'b0, 0, 0, 4);
    check("and_r6", 64'(dut_a.rf[6]), 64'h12345678);
    exec("or", 1'b0, 0, 0, 4);
    check("or_r7", 64'(dut_a.rf[7]), 64'h1234567D);
    exec("add_r0", 1'b0, 0, 0, 4);
    exec("sw_r0", 1'b0, 0, 0, 4);
    check("r0_zero", 64'(mem_a[36]), 64'h0);
    exec("bad_funct", 1'b0, 0, 0, 3);
    check("bad_funct_r3", 64'(dut_a.rf[3]), 64'h1);

    exec("beq_taken", 1'b0, 0, 0, 3);
    check("beq_taken_pc", 64'(pc_a), 64'h148);
    exec("beq_not", 1'b0, 0, 0, 3);
    check("beq_not_pc", 64'(pc_a), 64'h14C);
    check("beq_skip_r3", 64'(dut_a.rf[3]), 64'h1);
    exec("nop", 1'b0, 0, 0, 2);
    check("nop_pc", 64'(pc_a), 64'h150);
`ifdef MC_CORE_BNE_EN
    exec("bne", 1'b0, 0, 0, 3);
    check("bne_pc", 64'(pc_a), 64'h15C);
`else
    exec("bne_nop", 1'b0, 0, 0, 2);
    check("bne_pc", 64'(pc_a), 64'h154);
`endif
    exec("jump", 1'b0, 0, 0, 3);
    check("jump_pc", 64'(pc_a), 64'h100);
    reset_a = 1'b0;

    reset_b = 1'b1;
    b_prologue();
    check("b_r9_to_r1", dut_b.rf[1], 64'h7);
    check("b_r2_sext", dut_b.rf[2], 64'hFFFFFFFFFFFFFFFF);
    check("b_r3", dut_b.rf[3], 64'h55);
    tick(); tick(); tick();
    check("b_in_memrd", 64'(st_b), 64'h3);
    check("b_memrd_adr", adr_b, 64'h40);
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    check("b_abort_rd_state", 64'(st_b), 64'h0);
    check("b_abort_rd_pc", pc_b, 64'h100);
    check("b_abort_rd_r3", dut_b.rf[3], 64'h55);

    b_prologue();
    tick(); tick(); tick(); tick();
    check("b_in_memwb", 64'(st_b), 64'h4);
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    check("b_abort_wb_pc", pc_b, 64'h100);
    check("b_abort_wb_r3", dut_b.rf[3], 64'h55);

    b_prologue();
    exec("b_lw", 1'b1, 0, 0, 5);
    check("b_lw_r3", dut_b.rf[3], 64'h0123456789ABCDEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_core_p.md
Name: mc_core_p

Overview:
- Parametrised multicycle MIPS-subset core: generalised multicycle datapath plus integrated main/ALU-decoder FSM.
- Adds three things over the current datapath:
  - configurable data width and register count;
  - memory wait-state handshake;
  - jump support via a 3-way next-PC select.
- Single unified instruction/data memory sits outside the block on the mem_* interface.

Parameters:
- WIDTH, 32, data/address/register width; legal values 32 or 64. Instruction is always mem_rd[31:0].
- NREG, 32, register count; legal values 8, 16 or 32. Register index is the low log2(NREG) bits of the rs/rt/rd field.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- mem_adr  out  WIDTH  memory address: PC when IorD=0, ALUOut when IorD=1.
- mem_wd  out  WIDTH  store data; equals register B.
- mem_we  out  1  memory write strobe.
- mem_rd  in  WIDTH  memory read data.
- mem_ready  in  1  memory access completes this cycle.
- pc  out  WIDTH  current PC.
- state  out  4  current FSM state encoding.

Behaviour:
- Reset (reset=0 at a clk edge):
  - pc=RESET_PC, state=FETCH, mem_we=0, mem_adr=RESET_PC, mem_wd=0.
  - IR, Data, A, B and ALUOut are all cleared.
  - Register file contents are not reset.
  - Reset mid-instruction aborts it; any write pending in that cycle is suppressed.
- Register file:
  - Two combinational read ports, one write port written at the clk edge.
  - Register 0 reads 0; writes to it are ignored.
- Immediates:
  - SignImm = sign-extend Instr[15:0] to WIDTH.
  - Branch offset = SignImm<<2.
  - Jump target = {pc[WIDTH-1:28], Instr[25:0], 2'b00}, with pc already incremented.
- ALU operations: add, sub, and, or, slt (signed, result 0/1). Zero = (result==0). Arithmetic wraps modulo 2^WIDTH.
- FSM states, encoding in parentheses:
  - FETCH(0): IorD=0, IRWrite, ALU pc+4.
    - If mem_ready=1: IR<=mem_rd[31:0], pc<=pc+4, go to DECODE.
    - If mem_ready=0: stay in FETCH; IR and pc unchanged.
  - DECODE(1): A<=rs, B<=rt, ALUOut<=pc+(SignImm<<2). Dispatch on opcode:
    - lw 0x23 / sw 0x2B -> MEMADR
    - 0x00 -> EXEC
    - beq 0x04 -> BRANCH
    - addi 0x08 -> ADDIEX
    - j 0x02 -> JUMP
    - any other opcode -> FETCH (executes as a nop)
  - MEMADR(2): ALUOut<=A+SignImm. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): IorD=1.
    - If mem_ready=1: Data<=mem_rd, go to MEMWB.
    - Otherwise stay in MEMRD.
  - MEMWB(4): rt<=Data, go to FETCH.
  - MEMWR(5): IorD=1, mem_we=1.
    - If mem_ready=1: go to FETCH.
    - Otherwise stay in MEMWR with mem_we still 1 and address/data stable.
  - EXEC(6): ALUOut<=A op B, op selected by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
    - Unknown funct -> FETCH, no write.
    - Otherwise -> ALUWB.
  - ALUWB(7): rd<=ALUOut, go to FETCH.
  - BRANCH(8): compute A-B. If Zero: pc<=ALUOut. Go to FETCH.
  - ADDIEX(9): ALUOut<=A+SignImm, go to ADDIWB.
  - ADDIWB(10): rt<=ALUOut, go to FETCH.
  - JUMP(11): pc<=jump target, go to FETCH.
  - State encodings 12-15 are illegal; if ever entered, go to FETCH.
- Latency with mem_ready held at 1 (cycles, including FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, nop 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_we is asserted only in MEMWR.

Optional Feature:
- Macro: MC_CORE_BNE_EN.
- When defined: opcode 0x05 (bne) dispatches to BRANCH and takes the branch when Zero=0.
- When undefined: opcode 0x05 is an unknown opcode and executes as a nop.

Test Plan:
- Reset: hold reset=0 for 2 cycles with RESET_PC=0x100, then release -> pc=0x100, state=0, mem_we=0, mem_adr=0x100; first FETCH then reads address 0x100.
- lw then addi: mem[0x40]=0xDEADBEEF, r1=0x30, execute lw r2,0x10(r1) -> r2=0xDEADBEEF after 5 cycles. Then addi r3,r2,-1 -> r3=0xDEADBEEE.
- sw with wait states: r4=0x12345678, execute sw r4,4(r0) with mem_ready=0 for 3 cycles in MEMWR -> mem_we held for 4 cycles at mem_adr=4 with mem_wd=0x12345678; mem[4] written; instruction takes 7 cycles.
- R-type and slt:
  - r1=5, r2=-3: slt r3,r1,r2 -> r3=0; slt r3,r2,r1 -> r3=1.
  - sub r5,r2,r1 -> r5=0xFFFFFFF8.
  - add r0,r1,r1 -> r0 still reads 0.
- Branch and jump:
  - beq r1,r1,+2 at pc=0x20 -> pc=0x2C.
  - beq with unequal registers -> pc=0x24.
  - j 0x40 at pc=0x24 -> pc=0x100.
  - With MC_CORE_BNE_EN defined, bne on unequal registers is taken.
- Width/reset abort: WIDTH=64, NREG=8.
  - addi r9,r0,7 writes r1, since index = low 3 bits.
  - Assert reset during MEMRD -> no register write occurs; pc=RESET_PC.
